uart_transmitter: RTL
=====================

// Module: uart_transmitter
// PURPOSE
//  8N1 UART serialiser for the board's USB-UART TX line; the counterpart of the calculator's UART receive path.
//  Accepts a byte via a valid/ready handshake and shifts it out on TxD, LSB first, at baud_rate.
//  A one-entry holding register lets the next byte be queued while the current frame shifts, so frames go out back-to-back.
// PARAMETERS
//  clk_freq   100_000_000  system clock frequency, Hz
//  baud_rate  9_600        line rate, bits/s
//  stop_bits  1            stop bits per frame; legal values 1 or 2
//  div_bit    clk_freq/baud_rate (=10416)  clocks per bit, derived, integer division
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  reset     in   1  asynchronous, active-high reset
//  tx_data   in   8  byte to send; sampled on the handshake edge
//  tx_valid  in   1  tx_data is valid; hold until tx_ready
//  tx_ready  out  1  holding register empty; a byte is accepted on a posedge where tx_valid & tx_ready
//  TxD       out  1  serial line, idle high
//  busy      out  1  a frame is on the line (START/DATA/STOP)
//  done      out  1  one-cycle pulse on the final clock of each frame's last stop bit
// BEHAVIOUR
//  Reset (async, immediate): TxD=1, busy=0, done=0, tx_ready=1, holding reg empty, state=IDLE, counters=0.
//   Reset mid-frame abandons the frame at once; TxD returns high without a stop bit; the queued byte is discarded.
//  Handshake: on an accepting edge, tx_data goes into the holding reg and tx_ready=0 from that edge on.
//   tx_valid while tx_ready=0 is ignored; tx_data is not sampled.
//  FSM states: IDLE, START, DATA, STOP. Registered outputs only; TxD is driven from a flop.
//   IDLE: TxD=1, busy=0. If holding full: move byte into shift reg, set tx_ready=1, go to START, clear bit-timer.
//   START: TxD=0 for div_bit clocks, then go to DATA with bit index 0.
//   DATA: TxD=shift[0] for div_bit clocks per bit, shift right each bit; after bit 7 go to STOP.
//   STOP: TxD=1 for stop_bits*div_bit clocks; done=1 on the last of those clocks.
//    At STOP end, if holding full: go straight to START; there is no idle clock between frames.
//    At STOP end, if holding empty: go to IDLE.
//  Latency: byte accepted at edge N from IDLE -> TxD falls after edge N+1. Frame length = (9+stop_bits)*div_bit clocks.
//  Bit timer: 14-bit counter, 0..div_bit-1; wraps at div_bit-1 and advances the bit/state there. It is cleared on entry to START.
//  Simultaneous events: tx_valid on the same edge the holding reg empties into the shifter is not accepted.
//   tx_ready rises after that edge, and the byte is accepted on the following edge.
//  busy=1 from the START entry edge to the edge leaving STOP into IDLE. busy stays 1 across back-to-back frames.
//  Widths: bit index 3 bits; stop counter 1 bit. No parity; no break generation.
// STRUCTURE
//  Shared package uart_pkg: clk_freq, baud_rate, div_bit and the FSM state encoding localparams.
//   The same constants are used by the receive path.
//  Sub-module uart_baud_tick is optional: it holds the bit-timer counter, with clear input and a tick output on the last clock of a bit.
//  Everything else stays in one always block for state/data plus one for the holding register.
// TESTING (bench uses div_bit override 16 for speed, plus one run at the default 10416)
//  1. Reset released, no tx_valid for 100 clocks -> TxD=1, busy=0, tx_ready=1, done never pulses.
//  2. Send 0x55 -> TxD bit sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly div_bit clocks.
//     The start edge is 1 clock after acceptance; done pulses once, at clock 10*div_bit.
//  3. Send 0xA3 and queue 0x0F while busy -> second start bit begins the clock after the first stop bit ends.
//     busy stays 1 throughout; done pulses twice; decoded bytes are 0xA3 then 0x0F.
//  4. Hold tx_valid with 0x11, 0x22, 0x33 -> tx_ready gates each byte, exactly 3 frames go out, none is lost or duplicated.
//  5. stop_bits=2, send 0xFF -> TxD low for exactly 1 bit, then high for 10 bits. Frame length is 11*div_bit.
//  6. Assert reset mid-DATA (bit 4 of 0x00) -> TxD=1 within the same clock without waiting for an edge.
//     After release the block is idle, tx_ready=1 and nothing is retransmitted.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants and TX state encoding shared by the UART TX and RX paths.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    localparam int c_CLK_FREQ  = 100_000_000;
    localparam int c_BAUD_RATE = 9_600;
    localparam int c_DIV_BIT   = c_CLK_FREQ / c_BAUD_RATE;
    localparam int c_TIMER_W   = 14;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_START = c_ST_START,
        ST_DATA  = c_ST_DATA,
        ST_STOP  = c_ST_STOP
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit timer counting 0..DIV_BIT-1; tick on the last clock of a bit.
// Revision    : 1.0
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_BIT = c_DIV_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick,
    output logic o_penult
);

    localparam logic [c_TIMER_W-1:0] c_LAST   = c_TIMER_W'(DIV_BIT - 1);
    localparam logic [c_TIMER_W-1:0] c_PENULT = c_TIMER_W'(DIV_BIT - 2);

    logic [c_TIMER_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_TIMER_W'(1);
        end
    end

    assign o_tick   = (r_cnt == c_LAST);
    // One clock early so a registered output can land on the last clock of a bit.
    assign o_penult = (r_cnt == c_PENULT);

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1/8N2 UART serialiser with one-entry holding register.
// Revision    : 1.0
// ============================================================================
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = c_CLK_FREQ,
    parameter int BAUD_RATE = c_BAUD_RATE,
    parameter int STOP_BITS = 1,
    parameter int DIV_BIT   = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       busy,
    output logic       done
);

    localparam logic c_LAST_STOP = (STOP_BITS == 2);

    tx_state_t  r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [2:0] r_bit_idx, w_bit_idx_nxt;
    logic       r_stop_cnt, w_stop_cnt_nxt;
    logic       r_txd, w_txd_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       w_load;
    logic       w_tick;
    logic       w_penult;
    logic       w_timer_clr;

    assign w_timer_clr = (r_state == ST_IDLE);

    uart_baud_tick #(
        .DIV_BIT (DIV_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_timer_clr),
        .o_tick   (w_tick),
        .o_penult (w_penult)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_txd_nxt      = r_txd;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_txd_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_shift_nxt = r_hold;
                    w_state_nxt = ST_START;
                    w_txd_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_txd_nxt     = r_shift[0];
                    w_bit_idx_nxt = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt    = ST_STOP;
                        w_txd_nxt      = 1'b1;
                        w_stop_cnt_nxt = 1'b0;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_txd_nxt     = r_shift[1];
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                w_done_nxt = w_penult && (r_stop_cnt == c_LAST_STOP);
                if (w_tick) begin
                    if (r_stop_cnt != c_LAST_STOP) begin
                        w_stop_cnt_nxt = 1'b1;
                    end else if (r_hold_full) begin
                        // Back-to-back: next start bit follows with no idle clock.
                        w_load      = 1'b1;
                        w_shift_nxt = r_hold;
                        w_state_nxt = ST_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_txd_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Load and accept are exclusive: load needs a full holding reg, accept an empty one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (tx_valid && !r_hold_full) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end
    end

    assign tx_ready = ~r_hold_full;
    assign TxD      = r_txd;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire
